// File: rtl/posit_pkg.sv
// posit_pkg: shared helpers for the posit decode pipeline.
//   clog2()        - ceiling log2 usable in constant expressions
//   regime_width() - bits needed for the signed regime value k of an n-bit posit
//   nar_pattern()  - NaR bit pattern (1 followed by n-1 zeros), right-aligned in MAX_N bits
//   ZERO_PATTERN   - zero bit pattern, right-aligned in MAX_N bits
package posit_pkg;

  localparam int MAX_N = 64;

  localparam logic [MAX_N-1:0] ZERO_PATTERN = '0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // k spans [-(n-1), n-2], which always fits in clog2(n)+1 signed bits.
  function automatic int regime_width(input int n);
    return clog2(n) + 1;
  endfunction

  function automatic logic [MAX_N-1:0] nar_pattern(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/posit_run_count.sv
// posit_run_count: combinational leading-run counter.
//   bits       in  W    field to scan, MSB first
//   run_len    out MW   number of leading bits equal to bits[W-1]
//   term_found out 1    a bit differing from the run exists below it
module posit_run_count
  import posit_pkg::*;
#(
  parameter int W = 15,
  localparam int MW = clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [MW-1:0] run_len,
  output logic          term_found
);

  always_comb begin
    run_len    = '0;
    term_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!term_found) begin
        if (bits[i] == bits[W-1]) run_len = run_len + MW'(1);
        else                      term_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: three-stage pipelined posit decoder with valid/ready.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid | out_ready
//   in_data   [N]         raw posit
//   out_valid/out_ready   output handshake; outputs hold while stalled
//   out_sign              sign bit (0 for zero, 1 for NaR)
//   out_regime [RW]       signed regime value k
//   out_exp   [max(ES,1)] exponent bits, zero-padded when truncated
//   out_frac  [N]         fraction bits after the hidden bit, MSB-aligned
//   out_zero, out_nar     special-value flags
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 3,
  parameter int RW = regime_width(N),
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exp,
  output logic [N-1:0]         out_frac,
  output logic                 out_zero,
  output logic                 out_nar
);

  localparam int MW = clog2(N);
  localparam logic [MAX_N-1:0] NAR_WIDE = nar_pattern(N);
  localparam logic [N-1:0]     NAR_PAT  = NAR_WIDE[N-1:0];
  localparam logic [N-1:0]     ZERO_PAT = ZERO_PATTERN[N-1:0];

  typedef struct packed {
    logic         sign;
    logic         zero;
    logic         nar;
    logic [N-2:0] mag;
  } s1_t;

  // rem holds the bits after the regime terminator, left-aligned.
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [RW-1:0] k;
    logic [N-2:0]         rem;
  } s2_t;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [RW-1:0] k;
    logic [EW-1:0]        ex;
    logic [N-1:0]         frac;
  } s3_t;

  s1_t  s1_p1_d, s1_p1_q;
  s2_t  s2_p2_d, s2_p2_q;
  s3_t  s3_p3_d, s3_p3_q;
  logic vld_p1_d, vld_p1_q;
  logic vld_p2_d, vld_p2_q;
  logic out_valid_d, out_valid_q;
  logic en;

  logic [N-2:0]         run_bits;
  logic [MW-1:0]        run_len;
  logic                 term_found;
  logic signed [RW-1:0] run_s;

  // One enable moves every stage together; a stalled output freezes the pipe.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    vld_p1_d    = vld_p1_q;
    vld_p2_d    = vld_p2_q;
    out_valid_d = out_valid_q;
    if (en) begin
      vld_p1_d    = in_valid;
      vld_p2_d    = vld_p1_q;
      out_valid_d = vld_p2_q;
    end
  end

  // Stage 1: capture sign, absolute value and special-value flags.
  // Only the low N-1 bits of the magnitude are needed downstream.
  always_comb begin
    s1_p1_d = s1_p1_q;
    if (en) begin
      s1_p1_d.sign = in_data[N-1];
      s1_p1_d.mag  = in_data[N-1] ? -in_data[N-2:0] : in_data[N-2:0];
      s1_p1_d.zero = (in_data == ZERO_PAT);
      s1_p1_d.nar  = (in_data == NAR_PAT);
    end
  end

  // Stage 2: regime run length and left-aligned remainder.
  assign run_bits = s1_p1_q.mag;

  posit_run_count #(.W(N - 1)) u_run_count (
    .bits       (run_bits),
    .run_len    (run_len),
    .term_found (term_found)
  );

  assign run_s = signed'(RW'(run_len));

  always_comb begin
    s2_p2_d = s2_p2_q;
    if (en) begin
      s2_p2_d.sign = s1_p1_q.sign;
      s2_p2_d.zero = s1_p1_q.zero;
      s2_p2_d.nar  = s1_p1_q.nar;
      s2_p2_d.k    = run_bits[N-2] ? run_s - RW'(1) : -run_s;
      // Shift out the run and its terminator; with no terminator nothing remains.
      s2_p2_d.rem  = term_found ? (run_bits << ({1'b0, run_len} + 1'b1)) : '0;
    end
  end

  // Stage 3: split remainder into exponent and fraction, apply specials.
  // Zero fill from the stage-2 shift gives the truncated-exponent padding.
  always_comb begin
    s3_p3_d = s3_p3_q;
    if (en) begin
      s3_p3_d.zero = s2_p2_q.zero;
      s3_p3_d.nar  = s2_p2_q.nar;
      if (s2_p2_q.zero || s2_p2_q.nar) begin
        s3_p3_d.sign = s2_p2_q.nar;
        s3_p3_d.k    = '0;
        s3_p3_d.ex   = '0;
        s3_p3_d.frac = '0;
      end else begin
        s3_p3_d.sign = s2_p2_q.sign;
        s3_p3_d.k    = s2_p2_q.k;
        s3_p3_d.ex   = (ES > 0) ? s2_p2_q.rem[N-2 -: EW] : '0;
        s3_p3_d.frac = {s2_p2_q.rem, 1'b0} << ES;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      s3_p3_q     <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      s3_p3_q     <= s3_p3_d;
    end
  end

  // Internal data stages are qualified by the valid chain and need no reset.
  always_ff @(posedge clk) begin
    s1_p1_q <= s1_p1_d;
    s2_p2_q <= s2_p2_d;
  end

  assign out_valid  = out_valid_q;
  assign out_sign   = s3_p3_q.sign;
  assign out_regime = s3_p3_q.k;
  assign out_exp    = s3_p3_q.ex;
  assign out_frac   = s3_p3_q.frac;
  assign out_zero   = s3_p3_q.zero;
  assign out_nar    = s3_p3_q.nar;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe: three instances (N=16/ES=3, N=8/ES=0,
// N=32/ES=2) share handshake controls; expected fields are pushed into
// per-instance queues on accept and popped by negedge monitors.
module tb_posit_decode_pipe;

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               nar;
    logic signed [31:0] k;
    logic [63:0]        ex;
    logic [63:0]        frac;
  } fld_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready = 1'b1;
  bit   rand_ready = 1'b0;
  bit   lat_chk = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic              in_ready16, out_valid16, sign16, zero16, nar16;
  logic [15:0]       in16, frac16;
  logic signed [4:0] regime16;
  logic [2:0]        exp16;

  logic              in_ready8, out_valid8, sign8, zero8, nar8;
  logic [7:0]        in8, frac8;
  logic signed [3:0] regime8;
  logic [0:0]        exp8;

  logic              in_ready32, out_valid32, sign32, zero32, nar32;
  logic [31:0]       in32, frac32;
  logic signed [5:0] regime32;
  logic [1:0]        exp32;

  fld_t q16[$], q8[$], q32[$];
  int   stamp16[$];

  posit_decode_pipe #(.N(16), .ES(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_sign(sign16), .out_regime(regime16), .out_exp(exp16),
    .out_frac(frac16), .out_zero(zero16), .out_nar(nar16));

  posit_decode_pipe #(.N(8), .ES(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sign(sign8), .out_regime(regime8), .out_exp(exp8),
    .out_frac(frac8), .out_zero(zero8), .out_nar(nar8));

  posit_decode_pipe #(.N(32), .ES(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_data(in32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_sign(sign32), .out_regime(regime32), .out_exp(exp32),
    .out_frac(frac32), .out_zero(zero32), .out_nar(nar32));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Reference decoder: walks the bits in the order the posit format defines.
  function automatic fld_t model(input logic [63:0] raw, input int n, input int es);
    fld_t r;
    logic [63:0] x, mask;
    int i, m, pos;
    logic b;
    r = '0;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    x = raw & mask;
    if (x == 64'd0) begin
      r.zero = 1'b1;
      return r;
    end
    if (x == (64'd1 << (n - 1))) begin
      r.nar  = 1'b1;
      r.sign = 1'b1;
      return r;
    end
    r.sign = x[n-1];
    if (r.sign) x = (~x + 64'd1) & mask;
    i = n - 2;
    b = x[i];
    m = 0;
    while (i >= 0 && x[i] == b) begin
      m++;
      i--;
    end
    r.k = b ? m - 1 : -m;
    i--;
    for (int j = 0; j < es; j++) begin
      r.ex = {r.ex[62:0], (i >= 0) ? x[i] : 1'b0};
      i--;
    end
    pos = n - 1;
    while (i >= 0) begin
      r.frac[pos] = x[i];
      pos--;
      i--;
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_posit(input int n);
    logic [63:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v = {$urandom, $urandom};
    case (sel)
      0: v = '0;
      1: v = 64'd1 << (n - 1);
      2: v = (64'd1 << (n - 1)) - 64'd1;
      3: v = 64'd1;
      4: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_fld(input string nm, input fld_t a, input fld_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got s=%0b z=%0b nar=%0b k=%0d exp=%0h frac=%0h, expected s=%0b z=%0b nar=%0b k=%0d exp=%0h frac=%0h",
               nm, a.sign, a.zero, a.nar, a.k, a.ex, a.frac,
               e.sign, e.zero, e.nar, e.k, e.ex, e.frac);
    end
  endtask

  function automatic fld_t act16();
    fld_t a;
    a.sign = sign16; a.zero = zero16; a.nar = nar16;
    a.k = 32'(regime16); a.ex = 64'(exp16); a.frac = 64'(frac16);
    return a;
  endfunction

  function automatic fld_t act8();
    fld_t a;
    a.sign = sign8; a.zero = zero8; a.nar = nar8;
    a.k = 32'(regime8); a.ex = 64'(exp8); a.frac = 64'(frac8);
    return a;
  endfunction

  function automatic fld_t act32();
    fld_t a;
    a.sign = sign32; a.zero = zero32; a.nar = nar32;
    a.k = 32'(regime32); a.ex = 64'(exp32); a.frac = 64'(frac32);
    return a;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d16, input logic [7:0] d8, input logic [31:0] d32,
                      input bit use_ref, input fld_t e16);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in16 = d16; in8 = d8; in32 = d32;
    while (!ok) begin
      @(negedge clk);
      if (in_ready16) ok = 1'b1;
      else begin
        waited++;
        if (waited > 200) begin
          n_tests++;
          n_fail++;
          $display("FAIL accept timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
          break;
        end
      end
    end
    if (ok) begin
      q16.push_back(use_ref ? model(64'(d16), 16, 3) : e16);
      stamp16.push_back(cyc);
      q8.push_back(model(64'(d8), 8, 0));
      q32.push_back(model(64'(d32), 32, 2));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic dsend(input logic [15:0] d, input logic s, input logic z, input logic nr,
                       input int k, input logic [2:0] e, input logic [15:0] f);
    fld_t x;
    logic [63:0] r8, r32;
    x.sign = s; x.zero = z; x.nar = nr; x.k = k; x.ex = 64'(e); x.frac = 64'(f);
    r8 = rnd_posit(8);
    r32 = rnd_posit(32);
    send(d, r8[7:0], r32[31:0], 1'b0, x);
  endtask

  fld_t prev16;
  bit   stalled16 = 1'b0;

  always @(negedge clk) begin
    fld_t a;
    int lat;
    if (!rst_n) stalled16 = 1'b0;
    else begin
      a = act16();
      chk("in_ready vs stall", 64'(in_ready16), 64'(!(out_valid16 && !out_ready)));
      chk("n8 in_ready", 64'(in_ready8), 64'(in_ready16));
      chk("n32 in_ready", 64'(in_ready32), 64'(in_ready16));
      if (stalled16) begin
        chk("stall out_valid held", 64'(out_valid16), 64'd1);
        chk_fld("stall fields held", a, prev16);
      end
      if (out_valid16 && out_ready) begin
        if (q16.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL n16 unexpected output: got k=%0d frac=%0h, expected no output", a.k, a.frac);
        end else begin
          chk_fld("n16 fields", a, q16.pop_front());
          lat = cyc - stamp16.pop_front();
          if (lat_chk) chk("latency", 64'(lat), 64'd3);
          else         chk("latency at least 3", 64'(lat >= 3), 64'd1);
        end
      end
      stalled16 = out_valid16 && !out_ready;
      prev16 = a;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL n8 unexpected output: got valid 1, expected 0");
      end else chk_fld("n8 fields", act8(), q8.pop_front());
    end
    if (rst_n && out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL n32 unexpected output: got valid 1, expected 0");
      end else chk_fld("n32 fields", act32(), q32.pop_front());
    end
  end

  initial begin
    logic [63:0] r16, r8, r32;
    fld_t none;
    none = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in16 = '0; in8 = '0; in32 = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid16), 64'd0);
    chk("reset in_ready", 64'(in_ready16), 64'd1);
    chk_fld("reset n16 outputs", act16(), none);
    chk_fld("reset n8 outputs", act8(), none);
    chk_fld("reset n32 outputs", act32(), none);
    chk("reset n8/n32 out_valid", 64'({out_valid8, out_valid32}), 64'd0);
    @(posedge clk);
    #1;

    dsend(16'b0111001110110101, 0, 0, 0,   2, 3'b011, 16'b1011010100000000);
    dsend(16'b1000110001001011, 1, 0, 0,   2, 3'b011, 16'b1011010100000000);
    dsend(16'b0111111111111111, 0, 0, 0,  14, 3'b000, 16'h0000);
    dsend(16'b0000000000000001, 0, 0, 0, -14, 3'b000, 16'h0000);
    dsend(16'b0111111111111011, 0, 0, 0,  11, 3'b110, 16'h0000);
    dsend(16'b0000000000000000, 0, 1, 0,   0, 3'b000, 16'h0000);
    dsend(16'b1000000000000000, 1, 0, 1,   0, 3'b000, 16'h0000);
    repeat (6) @(posedge clk);
    #1;

    // Three entries in flight, then reset between edges.
    for (int i = 0; i < 3; i++) begin
      r16 = rnd_posit(16); r8 = rnd_posit(8); r32 = rnd_posit(32);
      send(r16[15:0], r8[7:0], r32[31:0], 1'b1, none);
    end
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'({out_valid16, out_valid8, out_valid32}), 64'd0);
    q16.delete(); q8.delete(); q32.delete(); stamp16.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no stale output after reset", 64'({out_valid16, out_valid8, out_valid32}), 64'd0);
    end
    @(posedge clk);
    #1;

    lat_chk = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      r16 = rnd_posit(16); r8 = rnd_posit(8); r32 = rnd_posit(32);
      send(r16[15:0], r8[7:0], r32[31:0], 1'b1, none);
    end
    rand_ready = 1'b0;
    for (int i = 0; i < 100 && (q16.size() + q8.size() + q32.size()) != 0; i++) @(negedge clk);
    chk("drain queues empty", 64'(q16.size() + q8.size() + q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
